// File: rtl/rice_core_pkg.sv
// Shared types and constants for the rice_core instruction-fetch slice.
// Optional build macro: RICE_CORE_IF_BUS_ERROR_EN (adds a bus-error flag to the IF result).
package rice_core_pkg;

    localparam int unsigned RICE_CORE_XLEN       = 32;
    localparam logic [31:0] RICE_CORE_NOP_INST   = 32'h0000_0013;
    localparam int unsigned RICE_CORE_INST_BYTES = 4;

    typedef struct packed {
        logic                      valid;
        logic [RICE_CORE_XLEN-1:0] pc;
        logic [31:0]               inst;
`ifdef RICE_CORE_IF_BUS_ERROR_EN
        logic                      error;
`endif
    } rice_core_if_result;

endpackage

// File: rtl/rice_core_if_fifo.sv
// Small synchronous FIFO used for the IF response buffer and the pc-tag queue.
// DEPTH must be a power of two; clear empties the FIFO and wins over push/pop.
module rice_core_if_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [0:(2**AW)-1];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            assert (!(push_i && full_o && !pop_i));
            assert (!(pop_i && empty_o));
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rice_core_if_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited fetch requests,
// pairs in-order responses with their PC and buffers them for a stalling ID stage.
// Optional build macro: RICE_CORE_IF_BUS_ERROR_EN (adds i_inst_rsp_error / o_if_error).
module rice_core_if_stage
    import rice_core_pkg::*;
#(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc,
    output logic            o_inst_req_valid,
    input  logic            i_inst_req_ready,
    output logic [XLEN-1:0] o_inst_req_addr,
    input  logic            i_inst_rsp_valid,
    input  logic [31:0]     i_inst_rsp_data,
`ifdef RICE_CORE_IF_BUS_ERROR_EN
    input  logic            i_inst_rsp_error,
    output logic            o_if_error,
`endif
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_pc,
    output logic [31:0]     o_if_inst
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
`ifdef RICE_CORE_IF_BUS_ERROR_EN
    localparam int unsigned ENTRY_W = XLEN + 32 + 1;
`else
    localparam int unsigned ENTRY_W = XLEN + 32;
`endif

    if (XLEN != RICE_CORE_XLEN) begin : g_xlen_check
        $error("rice_core_if_stage: XLEN must equal RICE_CORE_XLEN");
    end

    logic [XLEN-1:0]    pc_q, pc_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [CW-1:0]      discard_q, discard_d;
    rice_core_if_result res_q, res_d, ld_res;

    logic [ENTRY_W-1:0] rsp_wdata, rsp_rdata, src_word;
    logic [CW-1:0]      rsp_count, tag_count;
    logic               rsp_full, rsp_empty, tag_full, tag_empty;
    logic [XLEN-1:0]    tag_head;

    logic credit_ok, req_fire, rsp_keep, load_en, bypass;
    logic rsp_push, rsp_pop, tag_push, tag_pop;

    // Handshake and routing decisions for this cycle.
    always_comb begin
        credit_ok        = ({1'b0, outstanding_q} + {1'b0, rsp_count}) < (CW+1)'(FIFO_DEPTH);
        o_inst_req_valid = i_enable && !i_flush && credit_ok;
        o_inst_req_addr  = pc_q;
        req_fire         = o_inst_req_valid && i_inst_req_ready;
        rsp_keep         = i_inst_rsp_valid && !i_flush && (discard_q == '0);
        // An empty output slot may be refilled even while ID is stalled.
        load_en          = !i_stall || !res_q.valid;
        bypass           = rsp_keep && i_enable && rsp_empty && load_en;
        rsp_push         = rsp_keep && !bypass;
        rsp_pop          = !i_flush && i_enable && load_en && !rsp_empty;
        tag_push         = req_fire;
        tag_pop          = rsp_keep;
    end

`ifdef RICE_CORE_IF_BUS_ERROR_EN
    assign rsp_wdata = {i_inst_rsp_error, tag_head, i_inst_rsp_data};
`else
    assign rsp_wdata = {tag_head, i_inst_rsp_data};
`endif

    // Candidate for the output register: buffered head first, else the live response.
    always_comb begin
        src_word     = rsp_empty ? rsp_wdata : rsp_rdata;
        ld_res       = '0;
        ld_res.valid = 1'b1;
        ld_res.pc    = src_word[XLEN+31:32];
`ifdef RICE_CORE_IF_BUS_ERROR_EN
        ld_res.error = src_word[XLEN+32];
        ld_res.inst  = src_word[XLEN+32] ? RICE_CORE_NOP_INST : src_word[31:0];
`else
        ld_res.inst  = src_word[31:0];
`endif
    end

    // Next-state for PC, credit counters and the output register.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        res_d         = res_q;
        if (i_flush) begin
            pc_d          = i_flush_pc;
            // In-flight requests stay counted for credit until their responses drain.
            outstanding_d = outstanding_q - CW'(i_inst_rsp_valid);
            discard_d     = outstanding_q - CW'(i_inst_rsp_valid);
            res_d.valid   = 1'b0;
`ifdef RICE_CORE_IF_BUS_ERROR_EN
            res_d.error   = 1'b0;
`endif
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(RICE_CORE_INST_BYTES);
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(i_inst_rsp_valid);
            if (i_inst_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
            if (load_en) begin
                if (i_enable && (!rsp_empty || bypass)) begin
                    res_d = ld_res;
                end else begin
                    res_d.valid = 1'b0;
`ifdef RICE_CORE_IF_BUS_ERROR_EN
                    res_d.error = 1'b0;
`endif
                end
            end
        end
    end

    // State registers with protocol and credit sanity checks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            res_q         <= '0;
        end else begin
            assert (!(i_inst_rsp_valid && (outstanding_q == '0)));
            assert (!(req_fire && (outstanding_q == CW'(FIFO_DEPTH))));
            assert (discard_q <= outstanding_q);
            assert (tag_count == outstanding_q - discard_q);
            assert (!(rsp_push && rsp_full && !rsp_pop));
            assert (!(tag_push && tag_full));
            assert (!(tag_pop && tag_empty));
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            res_q         <= res_d;
        end
    end

    assign o_if_valid = res_q.valid;
    assign o_if_pc    = res_q.pc;
    assign o_if_inst  = res_q.inst;
`ifdef RICE_CORE_IF_BUS_ERROR_EN
    assign o_if_error = res_q.error;
`endif

    rice_core_if_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .clear_i (i_flush),
        .push_i  (rsp_push),
        .data_i  (rsp_wdata),
        .pop_i   (rsp_pop),
        .data_o  (rsp_rdata),
        .count_o (rsp_count),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );

    rice_core_if_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .clear_i (i_flush),
        .push_i  (tag_push),
        .data_i  (pc_q),
        .pop_i   (tag_pop),
        .data_o  (tag_head),
        .count_o (tag_count),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

endmodule
